// File: rtl/sparc_exu_yreg_file.sv
// sparc_exu_yreg_file: per-thread Y register file for the EXU mul/div path.
// W port is staged one cycle (w1) before commit; the G port commits directly
// unless blocked, in which case it is parked in a one-entry pending buffer.
// Optional macro YREG_RD_BYPASS_EN forwards this cycle's commit value to rd_data.
module sparc_exu_yreg_file #(
  parameter int NTHR  = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NTHR-1:0]  wr_w_en,
  input  logic [WIDTH-1:0] wr_w_data,
  input  logic [NTHR-1:0]  wr_g_en,
  input  logic [WIDTH-1:0] wr_g_data,
  input  logic [NTHR-1:0]  shift_en,
  input  logic             shift_bit,
  input  logic [NTHR-1:0]  rd_thr,
  output logic [WIDTH-1:0] rd_data,
  output logic [NTHR-1:0]  lsb_l,
  output logic             pend_vld,
  output logic             collide_err
);
  localparam int PW = (NTHR > 1) ? $clog2(NTHR) : 1;

  logic [NTHR-1:0]             w1_en_q;
  logic [WIDTH-1:0]            w1_data_q;
  logic [NTHR-1:0][WIDTH-1:0]  y_q, y_d;
  logic                        pend_vld_q, pend_vld_d;
  logic [PW-1:0]               pend_thr_q, pend_thr_d;
  logic [WIDTH-1:0]            pend_data_q, pend_data_d;
  logic                        err_q, err_d;

  logic                        drain, free, found, multi;
  logic [PW-1:0]               sel;
  logic [NTHR-1:0]             pend_hit, defer;

  // Pending entry drains whenever the staged W write is not aimed at its thread.
  always_comb begin
    drain = pend_vld_q & ~w1_en_q[pend_thr_q];
    free  = ~pend_vld_q | drain;
  end

  // Per-thread next Y: w1 > pending drain > G > shift > hold.
  always_comb begin
    y_d      = y_q;
    pend_hit = '0;
    defer    = '0;
    for (int t = 0; t < NTHR; t++) begin
      pend_hit[t] = drain && (pend_thr_q == PW'(t));
      defer[t]    = wr_g_en[t] & (w1_en_q[t] | pend_hit[t]);
      if (w1_en_q[t])
        y_d[t] = w1_data_q;
      else if (pend_hit[t])
        y_d[t] = pend_data_q;
      else if (wr_g_en[t])
        y_d[t] = wr_g_data;
      else if (shift_en[t])
        y_d[t] = {shift_bit, y_q[t][WIDTH-1:1]};
    end
  end

  // Pending buffer: capture the lowest-index blocked G write if a slot is
  // free (it may be draining this same cycle); every other blocked write is lost.
  always_comb begin
    found = 1'b0;
    multi = 1'b0;
    sel   = '0;
    for (int t = 0; t < NTHR; t++) begin
      if (defer[t]) begin
        if (!found) begin
          found = 1'b1;
          sel   = PW'(t);
        end else begin
          multi = 1'b1;
        end
      end
    end
    pend_vld_d  = pend_vld_q & ~drain;
    pend_thr_d  = pend_thr_q;
    pend_data_d = pend_data_q;
    err_d       = 1'b0;
    if (found) begin
      if (free) begin
        pend_vld_d  = 1'b1;
        pend_thr_d  = sel;
        pend_data_d = wr_g_data;
        err_d       = multi;
      end else begin
        err_d       = 1'b1;
      end
    end
  end

  // State registers; reset clears Y, staging, pending and the error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      w1_en_q     <= '0;
      w1_data_q   <= '0;
      y_q         <= '0;
      pend_vld_q  <= 1'b0;
      pend_thr_q  <= '0;
      pend_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      w1_en_q     <= wr_w_en;
      w1_data_q   <= wr_w_data;
      y_q         <= y_d;
      pend_vld_q  <= pend_vld_d;
      pend_thr_q  <= pend_thr_d;
      pend_data_q <= pend_data_d;
      err_q       <= err_d;
    end
  end

  // Read mux: OR of all selected threads (multi-hot is legal).
  always_comb begin
    rd_data = '0;
    for (int t = 0; t < NTHR; t++) begin
      if (rd_thr[t]) begin
`ifdef YREG_RD_BYPASS_EN
        rd_data = rd_data | y_d[t];
`else
        rd_data = rd_data | y_q[t];
`endif
      end
    end
  end

  // Active-low LSB of every thread, always from registered state.
  always_comb begin
    lsb_l = '0;
    for (int t = 0; t < NTHR; t++) lsb_l[t] = ~y_q[t][0];
  end

  assign pend_vld    = pend_vld_q;
  assign collide_err = err_q;

endmodule

// File: tb/tb_sparc_exu_yreg_file.sv
// Bench for sparc_exu_yreg_file (default build, no read bypass).
// Expected per-cycle outputs are queued as stimulus is applied and popped
// and compared at the following negedge.
module tb_sparc_exu_yreg_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wr_w_en, wr_g_en, shift_en, rd_thr;
  logic [31:0] wr_w_data, wr_g_data;
  logic        shift_bit;
  logic [31:0] rd_data;
  logic [3:0]  lsb_l;
  logic        pend_vld, collide_err;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic [3:0]  lsb;
    logic        pend;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sparc_exu_yreg_file #(.NTHR(4), .WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .wr_w_en(wr_w_en), .wr_w_data(wr_w_data),
    .wr_g_en(wr_g_en), .wr_g_data(wr_g_data),
    .shift_en(shift_en), .shift_bit(shift_bit),
    .rd_thr(rd_thr), .rd_data(rd_data), .lsb_l(lsb_l),
    .pend_vld(pend_vld), .collide_err(collide_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Queue this cycle's expectation, compare at negedge, advance to next cycle.
  task automatic cyc(input string tag, input logic [31:0] rd, input logic [3:0] lsb,
                     input logic pend, input logic err);
    exp_t e;
    e.tag = tag; e.rd = rd; e.lsb = lsb; e.pend = pend; e.err = err;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".rd"},   64'(rd_data),     64'(e.rd));
    chk({e.tag, ".lsb"},  64'(lsb_l),       64'(e.lsb));
    chk({e.tag, ".pend"}, 64'(pend_vld),    64'(e.pend));
    chk({e.tag, ".err"},  64'(collide_err), 64'(e.err));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_w_en = '0; wr_g_en = '0; shift_en = '0; shift_bit = 1'b0;
    wr_w_data = '0; wr_g_data = '0;
  endtask

  initial begin
    rst = 1'b1; rd_thr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    rd_thr = 4'b0100;
    cyc("rst", 32'h0, 4'b1111, 1'b0, 1'b0);

    // W latency: visible two cycles after presentation
    rd_thr = 4'b0010;
    wr_w_en = 4'b0010; wr_w_data = 32'hDEADBEEF;
    cyc("wlat0", 32'h0, 4'b1111, 0, 0);
    idle();
    cyc("wlat1", 32'h0, 4'b1111, 0, 0);
    cyc("wlat2", 32'hDEADBEEF, 4'b1101, 0, 0);

    // collision deferral: G to thr0 while w1 targets thr0
    rd_thr = 4'b0001;
    wr_w_en = 4'b0001; wr_w_data = 32'h11;
    cyc("col0", 32'h0, 4'b1101, 0, 0);
    idle(); wr_g_en = 4'b0001; wr_g_data = 32'h22;
    cyc("col1", 32'h0, 4'b1101, 0, 0);
    idle();
    cyc("col2", 32'h11, 4'b1100, 1, 0);
    cyc("col3", 32'h22, 4'b1101, 0, 0);

    // overflow: pending thr0 held by w1 thr0, third G write dropped
    wr_w_en = 4'b0001; wr_w_data = 32'h44;
    cyc("ovf0", 32'h22, 4'b1101, 0, 0);
    wr_w_en = 4'b0001; wr_w_data = 32'h55; wr_g_en = 4'b0001; wr_g_data = 32'h66;
    cyc("ovf1", 32'h22, 4'b1101, 0, 0);
    idle(); wr_g_en = 4'b0001; wr_g_data = 32'h33;
    cyc("ovf2", 32'h44, 4'b1101, 1, 0);
    idle();
    cyc("ovf3", 32'h55, 4'b1100, 1, 1);
    cyc("ovf4", 32'h66, 4'b1101, 0, 0);
    cyc("ovf5", 32'h66, 4'b1101, 0, 0);

    // shift on thr2, then shift swallowed by a same-thread G write
    rd_thr = 4'b0100;
    wr_g_en = 4'b0100; wr_g_data = 32'h3;
    cyc("sh0", 32'h0, 4'b1101, 0, 0);
    idle(); shift_en = 4'b0100; shift_bit = 1'b1;
    cyc("sh1", 32'h3, 4'b1001, 0, 0);
    cyc("sh2", 32'h80000001, 4'b1001, 0, 0);
    wr_g_en = 4'b0100; wr_g_data = 32'h5;
    cyc("sh3", 32'hC0000000, 4'b1101, 0, 0);
    idle();
    cyc("sh4", 32'h5, 4'b1001, 0, 0);

    // multi-hot and empty read selects
    rd_thr = 4'b0101;
    cyc("rdor", 32'h67, 4'b1001, 0, 0);
    rd_thr = 4'b0000;
    cyc("rdnone", 32'h0, 4'b1001, 0, 0);

    // reset mid-operation with w1 and pending both live
    rd_thr = 4'b0001;
    wr_w_en = 4'b0001; wr_w_data = 32'hAA;
    cyc("mrst0", 32'h66, 4'b1001, 0, 0);
    wr_w_en = 4'b0001; wr_w_data = 32'hBB; wr_g_en = 4'b0001; wr_g_data = 32'hCC;
    cyc("mrst1", 32'h66, 4'b1001, 0, 0);
    idle(); rst = 1'b1;
    cyc("mrst2", 32'hAA, 4'b1001, 1, 0);
    rst = 1'b0;
    cyc("mrst3", 32'h0, 4'b1111, 0, 0);
    rd_thr = 4'b1111;
    cyc("mrst4", 32'h0, 4'b1111, 0, 0);
    cyc("mrst5", 32'h0, 4'b1111, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
